clint_tick_ctrl: RTL

- Wishbone master that programs the CLINT compare register to generate one-shot or periodic machine-timer ticks.
- Reads the 64-bit mtime race-free (hi/lo/hi) and computes target = mtime + period.
- Writes mtimecmp using the glitch-free sequence: hi ← all-ones, then lo, then hi.
- Sits between a config/control source (CSR block or small peripheral) and the CLINT slave port. It shares the CLINT's wb_clk_i/wb_rst_i.

---
 rtl/clint_tick_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/clint_tick_ctrl.sv
// Wishbone master that programs CLINT mtimecmp for one-shot or periodic machine-timer
// ticks: race-free hi/lo/hi read of mtime, then glitch-free hi-max/lo/hi compare write.
module clint_tick_ctrl #(
    parameter logic [31:0] MTIME_ADDR    = 32'h20000C08,
    parameter logic [31:0] MTIMECMP_ADDR = 32'h20000C00
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        periodic_i,
    input  logic [31:0] period_i,
    input  logic        mtip_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        tick_o,
    output logic        busy_o,
    output logic        armed_o,
    output logic [31:0] tick_cnt_o,
    output logic [3:0]  dbg_state
);
    // Bus handshake: in every access state cyc = stb = 1 with adr/dat/we held
    // constant; the access completes (and read data is captured) on the clock edge
    // where wbm_ack_i = 1, which may arrive in the same cycle as stb.
    typedef enum logic [3:0] {
        S_IDLE, S_RD_HI, S_RD_LO, S_RD_HI2, S_WR_MAX, S_WR_LO, S_WR_HI,
        S_ARMED, S_TICK, S_DIS_HI, S_DIS_LO
    } state_t;

    localparam logic [31:0] ALL_ONES         = 32'hFFFF_FFFF;
    localparam logic [31:0] MTIME_HI_ADDR    = MTIME_ADDR + 32'd4;
    localparam logic [31:0] MTIMECMP_HI_ADDR = MTIMECMP_ADDR + 32'd4;

    state_t      state_q, state_d;
    logic [31:0] period_q;
    logic        periodic_q;
    logic [63:0] target_q;
    logic [31:0] h1_q;
    logic [31:0] lo_q;
    logic        stop_q;
    logic [31:0] tick_cnt_q;
    logic        stop_pend;

    // A stop arriving in the same cycle as an ack is honoured right away.
    assign stop_pend = stop_q | stop_i;

    always_comb begin
        state_d   = state_q;
        wbm_cyc_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i && (period_i != 32'd0)) state_d = S_RD_HI;
            end
            S_RD_HI: begin
                wbm_cyc_o = 1'b1;
                wbm_adr_o = MTIME_HI_ADDR;
                if (wbm_ack_i) state_d = stop_pend ? S_DIS_HI : S_RD_LO;
            end
            S_RD_LO: begin
                wbm_cyc_o = 1'b1;
                wbm_adr_o = MTIME_ADDR;
                if (wbm_ack_i) state_d = stop_pend ? S_DIS_HI : S_RD_HI2;
            end
            S_RD_HI2: begin
                wbm_cyc_o = 1'b1;
                wbm_adr_o = MTIME_HI_ADDR;
                if (wbm_ack_i) begin
                    if (stop_pend)              state_d = S_DIS_HI;
                    else if (wbm_dat_i != h1_q) state_d = S_RD_LO;
                    else                        state_d = S_WR_MAX;
                end
            end
            S_WR_MAX: begin
                wbm_cyc_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_adr_o = MTIMECMP_HI_ADDR;
                wbm_dat_o = ALL_ONES;
                if (wbm_ack_i) state_d = stop_pend ? S_DIS_HI : S_WR_LO;
            end
            S_WR_LO: begin
                wbm_cyc_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_adr_o = MTIMECMP_ADDR;
                wbm_dat_o = target_q[31:0];
                if (wbm_ack_i) state_d = stop_pend ? S_DIS_HI : S_WR_HI;
            end
            S_WR_HI: begin
                wbm_cyc_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_adr_o = MTIMECMP_HI_ADDR;
                wbm_dat_o = target_q[63:32];
                if (wbm_ack_i) state_d = stop_pend ? S_DIS_HI : S_ARMED;
            end
            S_ARMED: begin
                if (stop_pend)   state_d = S_DIS_HI;
                else if (mtip_i) state_d = S_TICK;
            end
            S_TICK: begin
                state_d = (stop_pend || !periodic_q) ? S_DIS_HI : S_WR_MAX;
            end
            S_DIS_HI: begin
                wbm_cyc_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_adr_o = MTIMECMP_HI_ADDR;
                wbm_dat_o = ALL_ONES;
                if (wbm_ack_i) state_d = S_DIS_LO;
            end
            S_DIS_LO: begin
                wbm_cyc_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_adr_o = MTIMECMP_ADDR;
                wbm_dat_o = ALL_ONES;
                if (wbm_ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            period_q   <= '0;
            periodic_q <= 1'b0;
            target_q   <= '0;
            h1_q       <= '0;
            lo_q       <= '0;
            stop_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_IDLE)                    stop_q <= 1'b0;
            else if (stop_i && (state_q != S_IDLE))  stop_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_RD_HI) begin
                        period_q   <= period_i;
                        periodic_q <= periodic_i;
                        tick_cnt_q <= '0;
                    end
                end
                S_RD_HI: if (wbm_ack_i) h1_q <= wbm_dat_i;
                S_RD_LO: if (wbm_ack_i) lo_q <= wbm_dat_i;
                S_RD_HI2: begin
                    // A changed high word means lo wrapped between reads; retry lo.
                    if (wbm_ack_i) begin
                        if (wbm_dat_i != h1_q) h1_q <= wbm_dat_i;
                        else target_q <= {h1_q, lo_q} + {32'd0, period_q};
                    end
                end
                S_TICK: begin
                    tick_cnt_q <= tick_cnt_q + 32'd1;
                    if (periodic_q) target_q <= target_q + {32'd0, period_q};
                end
                default: ;
            endcase
        end
    end

    assign wbm_stb_o  = wbm_cyc_o;
    assign busy_o     = wbm_cyc_o;
    assign armed_o    = (state_q == S_ARMED);
    assign tick_o     = (state_q == S_TICK);
    assign tick_cnt_o = tick_cnt_q;
    assign dbg_state  = state_q;

endmodule
